// File: rtl/bcd_disp_pkg.sv
// Shared constants for the four-digit BCD display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to seven-segment decoder.
// Values above 9 show a dash.
module bcd_seg_dec
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_scan.sv
// Four-digit multiplexed BCD display scanner with guard
// blanking, leading-zero suppression and an invalid-digit flag.
module bcd_disp_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [15:0]     data;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            tick;
  logic [3:0]      digs [NDIG];
  logic [NDIG-1:0] zero_up;
  logic [NDIG-1:0] bad;
  logic [3:0]      cur;
  logic [6:0]      dec;
  logic            blank;

  assign tick = (cnt == LAST);

  // zero_up[i]: digits i..3 are all zero
  always_comb begin
    zero_up = '0;
    bad     = '0;
    for (int i = 0; i < NDIG; i++) begin
      digs[i] = data[4*i +: 4];
      bad[i]  = (digs[i] > 4'd9);
    end
    zero_up[NDIG-1] = (digs[NDIG-1] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--)
      zero_up[i] = zero_up[i+1] && (digs[i] == 4'd0);
  end

  assign cur = digs[idx];

  bcd_seg_dec u_dec (
    .bcd (cur),
    .seg (dec)
  );

  assign blank = (cnt < GUARD_C)
              || (blank_lz && (idx != 2'd0) && zero_up[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
      idx  <= '0;
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
      err  <= 1'b0;
    end else begin
      if (load)
        data <= din;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
      an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : dec;
      err <= |bad;
    end
  end

endmodule

// File: doc/bcd_disp_scan.md
BCD_DISP_SCAN -- requirements
Module: bcd_disp_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have parameter GUARD, default 2: anti-ghost blank cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: when high, capture din at this edge.
REQ-006 SHALL have port din, input, 16 bits: four BCD digits; din[3:0] is digit0 (least significant) and din[15:12] is digit3.
REQ-007 SHALL have port blank_lz, input, 1 bit: when high, blank leading zeros.
REQ-008 SHALL have port seg, output, 7 bits: registered segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port an, output, 4 bits: registered digit enables, active-low, one-hot-low or all high.
REQ-010 SHALL have port err, output, 1 bit: registered flag, high while any latched digit is greater than 9.

Function
REQ-011 SHALL hold a 16-bit data register, written from din on every edge where load=1.
REQ-012 SHALL run a prescaler cnt that counts 0..DIV-1 and wraps to 0; tick = (cnt==DIV-1).
REQ-013 SHALL run a 2-bit digit index idx that increments on tick and wraps from 3 to 0.
REQ-014 SHALL compute all outputs at each edge from the pre-edge cnt, idx and data values, giving one cycle of latency.
REQ-015 SHALL drive an=4'b1111 and seg=0 when the pre-edge cnt < GUARD.
REQ-016 SHALL otherwise drive an as all ones except bit idx, which is 0, with seg = decode(data digit idx).
REQ-017 SHALL use decode 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-018 SHALL decode any digit greater than 9 as dash 7'h40.
REQ-019 SHALL, when blank_lz=1, blank digit i (i>0) if digits i..3 are all zero; a blanked slot drives an=4'b1111 and seg=0.
REQ-020 SHALL never blank digit0.
REQ-021 SHALL, when load and tick occur on the same edge, perform both: new data is used from the next slot and the scan position is unaffected.
REQ-022 SHALL NOT reset cnt or idx on load.
REQ-023 SHALL update err one edge after the data register changes.
REQ-024 SHALL sample blank_lz combinationally each cycle; it is not latched.

Reset
REQ-025 SHALL, on an edge with rst=1, set data=0, cnt=0, idx=0, an=4'b1111, seg=0 and err=0.
REQ-026 SHALL give rst priority over a simultaneous load.
REQ-027 SHALL, on a mid-scan reset, discard the current slot; scanning restarts at digit0 with a full slot, including its guard.

Structure
REQ-028 SHALL place the segment constants (digits 0-9, dash, blank) and NDIG=4 in the shared display package.
REQ-029 SHALL implement the decoder as one sub-module, bcd_seg_dec: 4-bit input, 7-bit pattern output, dash for values greater than 9, purely combinational.
REQ-030 SHALL contain all counters, registers and blanking logic in bcd_disp_scan itself.

Verification (DIV=4, GUARD=1)
REQ-031 SHALL cover: rst, then load 16'h1234 with blank_lz=0 -> slots repeat an=1110/seg=66, 1101/4F, 1011/5B, 0111/06; each slot is 1 cycle of 1111/00 followed by 3 active cycles.
REQ-032 SHALL cover: load 16'h0007 with blank_lz=1 -> digit0 slot shows 1110/07; digit1-3 slots show 1111/00.
REQ-033 SHALL cover: load 16'h0000 with blank_lz=1 -> digit0 shows 1110/3F; err=0.
REQ-034 SHALL cover: load 16'h00A5 -> err=1 one edge later and the digit1 slot shows 1101/40; then load 16'h0005 -> err=0 one edge later.
REQ-035 SHALL cover: rst asserted while idx=2 together with load=1 -> next cycle an=1111, seg=00, err=0; after release, digit0 is the first slot shown and data=0.
REQ-036 SHALL cover: load 16'h9999 on the tick edge ending digit1 -> the digit2 slot shows 1011/6F and slot order is unchanged.
